// File: rtl/pc_stack_unit_pkg.sv
// pc_stack_unit_pkg: shared CPU sizing defaults and PC operation decode
package pc_stack_unit_pkg;
  localparam int CPU_WIDTH = 8;
  localparam int CPU_DEPTH = 4;
  localparam int CPU_STEP = 1;
  typedef enum logic [2:0] {OP_HOLD, OP_RET, OP_CALL, OP_LOAD, OP_INC} pc_op_e;
  function automatic pc_op_e decode_op(input logic ret, input logic call, input logic load, input logic inc);
    return ret ? OP_RET : call ? OP_CALL : load ? OP_LOAD : inc ? OP_INC : OP_HOLD;
  endfunction
endpackage

// File: rtl/pc_stack_unit_lifo.sv
// lifo_stack: bounded return-address stack, push ignored when full, pop ignored when empty
module lifo_stack
  import pc_stack_unit_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int DEPTH = CPU_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty
);
  localparam int SW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  assign full = sp == SW'(DEPTH);
  assign empty = sp == '0;
  // entry storage and pointer; push takes precedence if both are requested
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem <= '{default: '0};
      sp <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++)
        if (sp == SW'(i)) mem[i] <= din;
      sp <= sp + SW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SW'(1);
    end
  // top-of-stack read, zero when empty
  always_comb begin
    dout = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sp == SW'(i + 1)) dout = mem[i];
  end
endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with jump, step, call/return stack and bus driver
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int DEPTH = CPU_DEPTH,
  parameter int STEP = CPU_STEP
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_enable,
  input  logic                       inc_enable,
  input  logic                       call_enable,
  input  logic                       ret_enable,
  input  logic                       out_enable,
  input  logic                       clr_err,
  input  logic [WIDTH-1:0]           in_data,
  output logic [WIDTH-1:0]           out_data,
  output logic [WIDTH-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       overflow,
  output logic                       underflow
);
  pc_op_e op;
  logic [WIDTH-1:0] pc, pc_next, pc_step, top;
  logic push, pop;
  assign op = decode_op(ret_enable, call_enable, in_enable, inc_enable);
  assign pc_step = pc + WIDTH'(STEP);
  assign push = op == OP_CALL && !stack_full;
  assign pop = op == OP_RET && !stack_empty;
  lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(pc_step),
    .dout(top),
    .sp(sp),
    .full(stack_full),
    .empty(stack_empty)
  );
  // blocked call/return fall through to hold
  always_comb pc_next = pop ? top : (push || op == OP_LOAD) ? in_data : op == OP_INC ? pc_step : pc;
  // PC register
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else pc <= pc_next;
  // sticky error flags, a new event wins over clear
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow <= (op == OP_CALL && stack_full) || (overflow && !clr_err);
      underflow <= (op == OP_RET && stack_empty) || (underflow && !clr_err);
    end
  assign out_data = pc;
  assign data_out = out_enable ? pc : {WIDTH{1'bz}};
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed-vector check of the PC/return-stack unit
module tb_pc_stack_unit;
  logic clk = 1'b0;
  logic reset, in_enable, inc_enable, call_enable, ret_enable, out_enable, clr_err;
  logic [7:0] in_data;
  logic [7:0] out_data;
  wire  [7:0] data_out;
  logic [2:0] sp;
  logic stack_full, stack_empty, overflow, underflow;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] ret_exp [4] = '{8'h41, 8'h31, 8'h21, 8'h12};
  pc_stack_unit #(.WIDTH(8), .DEPTH(4), .STEP(1)) dut (
    .clk(clk),
    .reset(reset),
    .in_enable(in_enable),
    .inc_enable(inc_enable),
    .call_enable(call_enable),
    .ret_enable(ret_enable),
    .out_enable(out_enable),
    .clr_err(clr_err),
    .in_data(in_data),
    .out_data(out_data),
    .data_out(data_out),
    .sp(sp),
    .stack_full(stack_full),
    .stack_empty(stack_empty),
    .overflow(overflow),
    .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_op(input logic r, input logic c, input logic l, input logic i, input logic e, input logic [7:0] d);
    ret_enable = r;
    call_enable = c;
    in_enable = l;
    inc_enable = i;
    clr_err = e;
    in_data = d;
    @(posedge clk);
    #1;
    {ret_enable, call_enable, in_enable, inc_enable, clr_err} = '0;
    in_data = '0;
  endtask
  initial begin
    reset = 1'b1;
    {ret_enable, call_enable, in_enable, inc_enable, clr_err, out_enable} = '0;
    in_data = '0;
    #3;
    check("rst_pc", out_data, 8'h00);
    check("rst_sp", sp, 3'd0);
    check("rst_empty", stack_empty, 1'b1);
    check("rst_full", stack_full, 1'b0);
    check("rst_flags", {overflow, underflow}, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_op(1, 0, 0, 0, 0, 8'h00);
    check("pre_un", underflow, 1'b1);
    do_op(0, 0, 1, 0, 0, 8'h03);
    do_op(0, 1, 0, 0, 0, 8'h00);
    for (int k = 0; k < 5; k++) do_op(0, 0, 0, 1, 0, 8'h00);
    check("pre_pc", out_data, 8'h05);
    check("pre_sp", sp, 3'd1);
    #2 reset = 1'b1;
    #1;
    check("async_pc", out_data, 8'h00);
    check("async_sp", sp, 3'd0);
    check("async_un", underflow, 1'b0);
    check("async_empty", stack_empty, 1'b1);
    #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) do_op(0, 0, 0, 1, 0, 8'h00);
    check("inc3", out_data, 8'h03);
    do_op(0, 0, 1, 0, 0, 8'hFF);
    check("load_ff", out_data, 8'hFF);
    do_op(0, 0, 0, 1, 0, 8'h00);
    check("wrap", out_data, 8'h00);
    do_op(0, 0, 1, 0, 0, 8'h10);
    do_op(0, 1, 0, 0, 0, 8'h40);
    check("call_pc", out_data, 8'h40);
    check("call_sp", sp, 3'd1);
    do_op(1, 0, 0, 0, 0, 8'h00);
    check("ret_pc", out_data, 8'h11);
    check("ret_sp", sp, 3'd0);
    check("ret_empty", stack_empty, 1'b1);
    do_op(0, 1, 0, 0, 0, 8'h20);
    do_op(0, 1, 0, 0, 0, 8'h30);
    do_op(0, 1, 0, 0, 0, 8'h40);
    do_op(0, 1, 0, 0, 0, 8'h50);
    check("nest_pc", out_data, 8'h50);
    check("nest_sp", sp, 3'd4);
    check("nest_full", stack_full, 1'b1);
    check("nest_ov0", overflow, 1'b0);
    do_op(0, 1, 0, 0, 0, 8'h60);
    check("ov_pc", out_data, 8'h50);
    check("ov_sp", sp, 3'd4);
    check("ov_flag", overflow, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_op(1, 0, 0, 0, 0, 8'h00);
      check($sformatf("unwind%0d_pc", k), out_data, ret_exp[k]);
      check($sformatf("unwind%0d_sp", k), sp, 16'(3 - k));
    end
    check("unwind_empty", stack_empty, 1'b1);
    check("ov_sticky", overflow, 1'b1);
    do_op(0, 0, 0, 0, 1, 8'h00);
    check("ov_clr", overflow, 1'b0);
    do_op(0, 0, 1, 0, 0, 8'h22);
    do_op(1, 0, 0, 0, 0, 8'h00);
    check("un_pc", out_data, 8'h22);
    check("un_sp", sp, 3'd0);
    check("un_flag", underflow, 1'b1);
    do_op(0, 0, 0, 0, 1, 8'h00);
    check("un_clr", underflow, 1'b0);
    do_op(1, 0, 0, 0, 1, 8'h00);
    check("un_set_wins", underflow, 1'b1);
    do_op(0, 0, 0, 0, 1, 8'h00);
    do_op(0, 0, 1, 0, 0, 8'h07);
    do_op(0, 1, 0, 0, 0, 8'h10);
    check("prio_setup_pc", out_data, 8'h10);
    do_op(1, 1, 1, 1, 0, 8'h77);
    check("prio_ret_pc", out_data, 8'h08);
    check("prio_ret_sp", sp, 3'd0);
    check("prio_ret_ov", overflow, 1'b0);
    do_op(0, 0, 1, 1, 0, 8'h33);
    check("prio_load", out_data, 8'h33);
    do_op(0, 1, 1, 1, 0, 8'h55);
    check("prio_call_pc", out_data, 8'h55);
    check("prio_call_sp", sp, 3'd1);
    do_op(1, 0, 0, 0, 0, 8'h00);
    check("prio_call_ret", out_data, 8'h34);
    #1;
    check("bus_off", data_out === 8'h34, 1'b0);
    check("bus_off_pc", out_data, 8'h34);
    out_enable = 1'b1;
    #1;
    check("bus_on", data_out, 8'h34);
    @(posedge clk);
    #1;
    check("bus_hold_pc", out_data, 8'h34);
    check("bus_hold_drv", data_out, 8'h34);
    out_enable = 1'b0;
    #1;
    check("bus_release", data_out === 8'h34, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Program-counter register with a built-in hardware return-address stack for the mini-CPU control path. It extends the plain bus register with these operations:
- load (jump)
- parametrised-step increment
- call (push return address, then jump)
- return (pop into PC)

The PC drives the shared bus through a tri-state output and the fetch logic through a direct output. Stack full, empty, overflow and underflow status go to the control unit.

Parameters:
WIDTH, 8, PC and stack entry width in bits
DEPTH, 4, number of return-stack entries (>= 1)
STEP, 1, increment amount applied by inc_enable and used for the call return address

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears PC, stack pointer, stack contents and flags
in_enable  input  1  jump: load PC from in_data
inc_enable  input  1  PC <= PC + STEP
call_enable  input  1  push PC+STEP, then PC <= in_data
ret_enable  input  1  PC <= top of stack, pop
out_enable  input  1  drive data_out onto bus
clr_err  input  1  clear sticky overflow/underflow flags
in_data  input  WIDTH  jump/call target from bus
out_data  output  WIDTH  PC, direct read, always driven
data_out  output  WIDTH  PC when out_enable=1, else high-Z
sp  output  $clog2(DEPTH+1)  number of valid stack entries
stack_full  output  1  sp == DEPTH
stack_empty  output  1  sp == 0
overflow  output  1  sticky; call attempted while full
underflow  output  1  sticky; return attempted while empty

Behaviour:
- Reset (async, any time, including mid-operation): PC=0, sp=0, all stack entries=0, overflow=0, underflow=0. Combinational results of reset: stack_empty=1, stack_full=0.
- All state updates on rising clk. out_data, sp and flags reflect the new value one cycle after the enable is sampled.
- data_out is combinational: out_enable ? PC : 'bz. out_enable has no effect on state.
- Operation priority per cycle, highest first: ret_enable > call_enable > in_enable > inc_enable. Exactly one operation executes; lower-priority enables in the same cycle are ignored.
- ret, sp>0: PC <= stack[sp-1]; sp <= sp-1. The popped entry's content is don't-care afterwards.
- ret, sp==0: PC unchanged, sp unchanged, underflow <= 1.
- call, sp<DEPTH: stack[sp] <= PC+STEP (mod 2^WIDTH); sp <= sp+1; PC <= in_data.
- call, sp==DEPTH: no push, no jump, PC unchanged, overflow <= 1.
- in_enable: PC <= in_data. Stack untouched.
- inc_enable: PC <= PC+STEP, truncated to WIDTH bits. Wrap-around is silent, e.g. 8'hFF+1 -> 8'h00.
- No enable asserted: hold all state.
- clr_err: clears both sticky flags. If an overflow/underflow event occurs in the same cycle, set wins for that flag.
- stack_full and stack_empty are combinational decodes of sp.
- Stack is strictly LIFO. No wrap: sp saturates at 0 and DEPTH as described above.

Decomposition:
- Shared CPU defines header holds the defaults for WIDTH and DEPTH, so the control unit sizes sp consistently.
- The stack is a natural sub-module: lifo_stack, parametrised by WIDTH and DEPTH.
  - Inputs: push, pop, din.
  - Outputs: dout (top), sp, full, empty.
  - Behaviour: ignores push when full and pop when empty; async reset.
- pc_stack_unit holds the PC register, priority decode, sticky flags and tri-state driver.

Test Plan:
- Reset/increment: assert reset mid-count with PC=8'h05 -> PC, sp, flags 0 immediately, without waiting for a clock edge. Release reset, then 3 cycles inc_enable -> out_data=8'h03. Load 8'hFF then inc -> 8'h00.
- Call/return: PC=8'h10, call with in_data=8'h40 -> PC=8'h40, sp=1, stack[0]=8'h11. Then ret -> PC=8'h11, sp=0, stack_empty=1.
- Nested and overflow (DEPTH=4): 4 calls to 8'h20, 8'h30, 8'h40, 8'h50 -> sp=4, stack_full=1. A 5th call with in_data=8'h60 -> PC stays 8'h50, overflow=1. Then 4 returns unwind in exact reverse order.
- Underflow and clear: ret with sp=0, PC=8'h22 -> PC=8'h22, underflow=1. clr_err alone -> 0. clr_err together with ret on empty -> underflow stays 1.
- Priority: PC=8'h10, sp=1 holding 8'h08; assert ret, call (in_data=8'h77), in_enable and inc together -> PC=8'h08, sp=0, no push.
- Bus driver: out_enable=0 -> data_out all Z while out_data=PC. out_enable=1 -> data_out=PC in the same cycle. PC unchanged throughout.
